// File: rtl/ascon_pkg.sv
// ascon_pkg
// Shared constants and the loader state encoding for the ascon128_decrypt
// front-end (ascon_dec_frame_loader and ascon_word_deser).
//   WORDS_PER_FRAME : 32-bit words per input frame (key, nonce, ct, tag)
//   OUT_WORDS       : 32-bit plaintext words per output frame
//   *_BASE          : index of the first (most significant) word of each field
package ascon_pkg;

    localparam int WORDS_PER_FRAME = 16;
    localparam int OUT_WORDS       = 4;

    localparam logic [3:0] KEY_BASE   = 4'd0;
    localparam logic [3:0] NONCE_BASE = 4'd4;
    localparam logic [3:0] CT_BASE    = 4'd8;
    localparam logic [3:0] TAG_BASE   = 4'd12;

    localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_FRAME - 1);
    localparam logic [1:0] LAST_OUT  = 2'(OUT_WORDS - 1);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_SKIP    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4,
        S_EMIT    = 3'd5
    } loader_state_t;

endpackage

// File: rtl/ascon_word_deser.sv
// ascon_word_deser
// Collects the 16-word input frame into four 128-bit field registers
// (key, nonce, ct, tag; MSW of each field arrives first) and tracks the
// word position.
//   clk, rst_n            : clock, async active-low reset
//   wr, data, last        : accepted input word and its end-of-frame marker
//   clr                   : drops the frame-complete flag once the frame is taken
//   key/nonce/ct/tag      : field registers, held until the next accepted word
//   full                  : registered, a well-formed frame has been collected
//   early_last            : this accepted word carries last before word 15
//   missing_last          : this accepted word is word 15 without last
module ascon_word_deser
    import ascon_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [31:0]  data,
    input  logic         last,
    input  logic         clr,
    output logic [127:0] key,
    output logic [127:0] nonce,
    output logic [127:0] ct,
    output logic [127:0] tag,
    output logic         full,
    output logic         early_last,
    output logic         missing_last
);

    logic [3:0] count;
    logic [6:0] word_lsb;

    // word 0 of a field lands in bits [127:96], word 3 in [31:0]
    assign word_lsb     = {~count[1:0], 5'b0_0000};
    assign early_last   = wr && last && (count != LAST_WORD);
    assign missing_last = wr && !last && (count == LAST_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            key   <= '0;
            nonce <= '0;
            ct    <= '0;
            tag   <= '0;
            full  <= 1'b0;
        end else begin
            if (clr) begin
                full <= 1'b0;
            end
            if (wr) begin
                case (count[3:2])
                    KEY_BASE[3:2]:   key[word_lsb +: 32]   <= data;
                    NONCE_BASE[3:2]: nonce[word_lsb +: 32] <= data;
                    CT_BASE[3:2]:    ct[word_lsb +: 32]    <= data;
                    TAG_BASE[3:2]:   tag[word_lsb +: 32]   <= data;
                    default: ;
                endcase
                // any frame boundary, good or bad, restarts at word 0
                if (last || (count == LAST_WORD)) begin
                    count <= '0;
                end else begin
                    count <= count + 4'd1;
                end
                if (last && (count == LAST_WORD)) begin
                    full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ascon_dec_frame_loader.sv
// ascon_dec_frame_loader
// Front-end for ascon128_decrypt: loads a 16-word frame (key, nonce, ct, tag),
// runs the core's level start/done handshake, then streams the 128-bit
// plaintext out as 4 words with the authentication result.
//   clk, rst_n                       : clock, async active-low reset
//   s_valid/s_ready/s_data/s_last    : 32-bit input word stream
//   core_start, core_key/nonce/ct/tag: request to the decrypt core
//   core_pt, core_tag_valid, core_done : result from the decrypt core
//   m_valid/m_ready/m_data/m_last    : 32-bit plaintext output stream
//   m_auth_fail                      : frame failed authentication (with m_valid)
//   frame_err                        : one-cycle pulse on a malformed input frame
//   timeout_err                      : one-cycle pulse on core timeout
// Optional feature macro: ASCON_LOADER_TIMEOUT_EN adds a WAIT watchdog of
// TIMEOUT_CYCLES cycles; without it timeout_err is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_LOAD    | accepting frame words into the field registers
// S_SKIP    | dropping words of a frame that lacked s_last on word 15
// S_START   | frame complete, raising core_start
// S_WAIT    | core_start high, waiting for core_done
// S_RELEASE | core_start low, waiting for the core to drop core_done
// S_EMIT    | streaming the 4 plaintext words
module ascon_dec_frame_loader
    import ascon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    output logic         core_start,
    output logic [127:0] core_key,
    output logic [127:0] core_nonce,
    output logic [127:0] core_ct,
    output logic [127:0] core_tag,
    input  logic [127:0] core_pt,
    input  logic         core_tag_valid,
    input  logic         core_done,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         m_last,
    output logic         m_auth_fail,
    output logic         frame_err,
    output logic         timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    loader_state_t state;
    logic          wr;
    logic          clr;
    logic          full;
    logic          early_last;
    logic          missing_last;
    logic [127:0]  pt_q;
    logic          tag_ok_q;
    logic          aborted_q;
    logic [1:0]    out_idx;
    logic [31:0]   pt_word;

`ifdef ASCON_LOADER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wait_cnt;
    logic            timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // a collected frame blocks further input until START takes it
    assign s_ready = ((state == S_LOAD) && !full) || (state == S_SKIP);
    assign wr      = s_valid && s_ready && (state == S_LOAD);
    assign clr     = (state == S_START);

    ascon_word_deser u_deser (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (wr),
        .data         (s_data),
        .last         (s_last),
        .clr          (clr),
        .key          (core_key),
        .nonce        (core_nonce),
        .ct           (core_ct),
        .tag          (core_tag),
        .full         (full),
        .early_last   (early_last),
        .missing_last (missing_last)
    );

    assign pt_word     = pt_q[{~out_idx, 5'b0_0000} +: 32];
    assign m_valid     = (state == S_EMIT);
    assign m_data      = (m_valid && tag_ok_q) ? pt_word : 32'h0;
    assign m_last      = m_valid && (out_idx == LAST_OUT);
    assign m_auth_fail = m_valid && !tag_ok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LOAD;
            core_start <= 1'b0;
            frame_err  <= 1'b0;
            pt_q       <= '0;
            tag_ok_q   <= 1'b0;
            aborted_q  <= 1'b0;
            out_idx    <= '0;
`ifdef ASCON_LOADER_TIMEOUT_EN
            wait_cnt   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef ASCON_LOADER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                S_LOAD: begin
                    if (early_last || missing_last) begin
                        frame_err <= 1'b1;
                    end
                    if (missing_last) begin
                        state <= S_SKIP;
                    end else if (full) begin
                        state <= S_START;
                    end
                end
                S_SKIP: begin
                    if (s_valid && s_last) begin
                        state <= S_LOAD;
                    end
                end
                S_START: begin
                    core_start <= 1'b1;
                    aborted_q  <= 1'b0;
                    state      <= S_WAIT;
`ifdef ASCON_LOADER_TIMEOUT_EN
                    wait_cnt   <= TO_LOAD;
`endif
                end
                S_WAIT: begin
                    if (core_done) begin
                        pt_q       <= core_pt;
                        tag_ok_q   <= core_tag_valid;
                        core_start <= 1'b0;
                        state      <= S_RELEASE;
`ifdef ASCON_LOADER_TIMEOUT_EN
                    end else if (wait_cnt == '0) begin
                        core_start <= 1'b0;
                        timeout_q  <= 1'b1;
                        aborted_q  <= 1'b1;
                        state      <= S_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
`endif
                    end
                end
                S_RELEASE: begin
                    // the core may hold done for a while after start falls
                    if (!core_done) begin
                        out_idx <= '0;
                        state   <= aborted_q ? S_LOAD : S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (m_ready) begin
                        out_idx <= out_idx + 2'd1;
                        if (out_idx == LAST_OUT) begin
                            state <= S_LOAD;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_dec_frame_loader.sv
// tb_ascon_dec_frame_loader
// Directed bench for ascon_dec_frame_loader with a behavioural stub core.
// Stub core: tag_valid = (tag == GOOD_TAG); pt = ct ^ nonce when valid,
// otherwise DEADBEEF repeated. Done rises STUB_RUN cycles after start and is
// held for 2 cycles after start falls.
// Define ASCON_LOADER_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_ascon_dec_frame_loader;

    localparam logic [127:0] KEY      = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] NONCE    = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] CT       = 128'h1122334455667788_99AABBCCDDEEFF00;
    localparam logic [127:0] GOOD_TAG = 128'hCAFEF00D0BADC0DE_123456789ABCDEF0;
    localparam logic [127:0] BAD_TAG  = 128'hCAFEF00D0BADC0DE_123456789ABCDEF1;
    // CT ^ NONCE, worked out by hand
    localparam logic [127:0] PT_NOM   = 128'h01332157_4173619F_81B3A1D7_C1F3E11F;
    localparam int STUB_RUN = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         s_last = 1'b0;
    logic         core_start;
    logic [127:0] core_key, core_nonce, core_ct, core_tag;
    logic [127:0] core_pt;
    logic         core_tag_valid;
    logic         core_done;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [31:0]  m_data;
    logic         m_last;
    logic         m_auth_fail;
    logic         frame_err;
    logic         timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int start_rises = 0;
    int fe_cnt = 0;
    int to_cnt = 0;
    int out_beats = 0;
    logic start_prev = 1'b0;
    logic stub_hang = 1'b0;
    int run_cnt, hold_cnt;

    always #5 clk = ~clk;

    ascon_dec_frame_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .core_start     (core_start),
        .core_key       (core_key),
        .core_nonce     (core_nonce),
        .core_ct        (core_ct),
        .core_tag       (core_tag),
        .core_pt        (core_pt),
        .core_tag_valid (core_tag_valid),
        .core_done      (core_done),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_auth_fail    (m_auth_fail),
        .frame_err      (frame_err),
        .timeout_err    (timeout_err)
    );

    // stub decrypt core
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done      <= 1'b0;
            core_pt        <= '0;
            core_tag_valid <= 1'b0;
            run_cnt        <= 0;
            hold_cnt       <= 0;
        end else if (core_start && !core_done && !stub_hang) begin
            if (run_cnt == STUB_RUN - 1) begin
                core_done      <= 1'b1;
                core_tag_valid <= (core_tag == GOOD_TAG);
                core_pt        <= (core_tag == GOOD_TAG) ? (core_ct ^ core_nonce)
                                                         : {4{32'hDEADBEEF}};
                run_cnt        <= 0;
                hold_cnt       <= 0;
            end else begin
                run_cnt <= run_cnt + 1;
            end
        end else if (core_done && !core_start) begin
            if (hold_cnt == 1) begin
                core_done <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt + 1;
            end
        end
    end

    // event monitors
    always @(posedge clk) begin
        start_prev <= core_start;
        if (core_start && !start_prev) start_rises <= start_rises + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (timeout_err) to_cnt <= to_cnt + 1;
        if (m_valid && m_ready) out_beats <= out_beats + 1;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // presents one word and returns 1 ns after the edge that accepted it
    task automatic send_word(input logic [31:0] d, input logic l);
        int g = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!s_ready) begin
            check_eq("s_ready_wait", 128'(s_ready), 128'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] k, input logic [127:0] n,
                              input logic [127:0] c, input logic [127:0] t,
                              input int nwords, input int last_at);
        for (int i = 0; i < nwords; i++) begin
            logic [127:0] f;
            logic [31:0]  d;
            case (i / 4)
                0:       f = k;
                1:       f = n;
                2:       f = c;
                default: f = t;
            endcase
            if (i < 16) d = f[(3 - (i % 4)) * 32 +: 32];
            else        d = 32'hEE00_0000 + 32'(i);
            send_word(d, i == last_at);
        end
    endtask

    // takes 4 output words; word stall_word is held off for stall_cycles
    task automatic collect_out(input string tag, input logic [127:0] exp_pt,
                               input logic exp_fail, input int stall_word,
                               input int stall_cycles);
        for (int i = 0; i < 4; i++) begin
            int g = 0;
            logic [31:0] ew;
            ew = exp_fail ? 32'h0 : exp_pt[(3 - i) * 32 +: 32];
            while (!m_valid && g < 200) begin
                tick(1);
                g++;
            end
            if (!m_valid) begin
                check_eq({tag, "_valid_timeout"}, 128'(m_valid), 128'd1);
                return;
            end
            if (i == stall_word) begin
                m_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    tick(1);
                    check_eq({tag, "_stall_valid"}, 128'(m_valid), 128'd1);
                    check_eq({tag, "_stall_data"}, 128'(m_data), 128'(ew));
                end
                m_ready = 1'b1;
            end
            check_eq({tag, "_data"}, 128'(m_data), 128'(ew));
            check_eq({tag, "_last"}, 128'(m_last), 128'(i == 3));
            check_eq({tag, "_auth_fail"}, 128'(m_auth_fail), 128'(exp_fail));
            tick(1);
        end
    endtask

    initial begin
        int base_st, base_fe, base_out;
        tick(3);
        check_eq("rst_core_start", 128'(core_start), 128'd0);
        check_eq("rst_core_key", core_key, 128'd0);
        check_eq("rst_core_tag", core_tag, 128'd0);
        check_eq("rst_m_valid", 128'(m_valid), 128'd0);
        check_eq("rst_frame_err", 128'(frame_err), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check_eq("load_s_ready", 128'(s_ready), 128'd1);

        // nominal frame and start latency
        base_st = start_rises;
        base_out = out_beats;
        send_frame(KEY, NONCE, CT, GOOD_TAG, 16, 15);
        check_eq("nom_s_ready_busy", 128'(s_ready), 128'd0);
        tick(1);
        check_eq("nom_start_early", 128'(core_start), 128'd0);
        tick(1);
        check_eq("nom_start_3cyc", 128'(core_start), 128'd1);
        check_eq("nom_core_key", core_key, KEY);
        check_eq("nom_core_nonce", core_nonce, NONCE);
        check_eq("nom_core_ct", core_ct, CT);
        check_eq("nom_core_tag", core_tag, GOOD_TAG);
        collect_out("nom", PT_NOM, 1'b0, 4, 0);
        tick(10);
        check_eq("nom_idle_m_valid", 128'(m_valid), 128'd0);
        check_eq("nom_beats", 128'(out_beats - base_out), 128'd4);
        check_eq("nom_starts", 128'(start_rises - base_st), 128'd1);

        // authentication failure
        send_frame(KEY, NONCE, CT, BAD_TAG, 16, 15);
        collect_out("authfail", 128'd0, 1'b1, 4, 0);

        // early s_last on word 7
        base_st = start_rises;
        base_fe = fe_cnt;
        send_frame(KEY, NONCE, CT, GOOD_TAG, 8, 7);
        tick(8);
        check_eq("early_frame_err", 128'(fe_cnt - base_fe), 128'd1);
        check_eq("early_no_start", 128'(start_rises - base_st), 128'd0);
        check_eq("early_s_ready", 128'(s_ready), 128'd1);
        send_frame(KEY, NONCE, CT, GOOD_TAG, 16, 15);
        collect_out("after_early", PT_NOM, 1'b0, 4, 0);

        // missing s_last on word 15, then 3 dropped words
        base_st = start_rises;
        base_fe = fe_cnt;
        base_out = out_beats;
        send_frame(KEY, NONCE, CT, GOOD_TAG, 19, 18);
        tick(8);
        check_eq("miss_frame_err", 128'(fe_cnt - base_fe), 128'd1);
        check_eq("miss_no_start", 128'(start_rises - base_st), 128'd0);
        check_eq("miss_s_ready", 128'(s_ready), 128'd1);

        // backpressure on word 1 (m_ready 1-0-0-1), stub holds done after start falls
        send_frame(KEY, NONCE, CT, GOOD_TAG, 16, 15);
        collect_out("bp", PT_NOM, 1'b0, 1, 2);
        tick(12);
        check_eq("bp_starts", 128'(start_rises - base_st), 128'd1);
        check_eq("bp_beats", 128'(out_beats - base_out), 128'd4);
        check_eq("bp_fe_quiet", 128'(fe_cnt - base_fe), 128'd1);
        check_eq("bp_idle_start", 128'(core_start), 128'd0);

        // asynchronous reset while the core is running
        send_frame(KEY, NONCE, CT, GOOD_TAG, 16, 15);
        tick(2);
        check_eq("arst_pre_start", 128'(core_start), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_start_low", 128'(core_start), 128'd0);
        check_eq("arst_key_clear", core_key, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check_eq("arst_s_ready", 128'(s_ready), 128'd1);
        send_frame(KEY, NONCE, CT, GOOD_TAG, 16, 15);
        collect_out("post_arst", PT_NOM, 1'b0, 4, 0);

`ifdef ASCON_LOADER_TIMEOUT_EN
        begin
            int c = 0;
            int g = 0;
            base_out = out_beats;
            stub_hang = 1'b1;
            send_frame(KEY, NONCE, CT, GOOD_TAG, 16, 15);
            while (!core_start && g < 20) begin
                tick(1);
                g++;
            end
            check_eq("to_started", 128'(core_start), 128'd1);
            while (!timeout_err && c < 100) begin
                tick(1);
                c++;
            end
            check_eq("to_pulse_cycle", 128'(c), 128'd16);
            check_eq("to_start_low", 128'(core_start), 128'd0);
            tick(1);
            check_eq("to_single_pulse", 128'(timeout_err), 128'd0);
            check_eq("to_s_ready", 128'(s_ready), 128'd1);
            tick(10);
            check_eq("to_no_output", 128'(out_beats - base_out), 128'd0);
            check_eq("to_count", 128'(to_cnt), 128'd1);
            stub_hang = 1'b0;
        end
`else
        check_eq("no_timeout_pulses", 128'(to_cnt), 128'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
